// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one transmitter byte stream
// among N_REQ requesters. A grant is held for a whole packet, which ends on
// req_last or after MAX_BEATS accepted bytes, so messages never interleave.
//
// Optional feature (macro UART_TX_ARB_SRC_TAG_EN): each grant starts with a
// source tag byte TAG_BASE | grant_id before the owner's data bytes.
//
// Ports:
//   clk, nrst              clock, asynchronous active-low reset
//   req_valid/data/last    per-requester byte stream (requester i in data[8i+7:8i])
//   req_ready              per-requester accept (only the owner's bit can be high)
//   tx_valid/tx_data       byte stream to the transmitter
//   tx_ready               transmitter accept
//   busy                   a grant is held
//   grant_id               current owner, valid only while busy
module uart_tx_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter logic [15:0] MAX_BEATS = 16'd64,
  parameter logic [7:0]  TAG_BASE  = 8'h80
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [8*N_REQ-1:0]         req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       tx_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_ready,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);

  localparam int unsigned IdW = $clog2(N_REQ);

`ifdef UART_TX_ARB_SRC_TAG_EN
  typedef enum logic [1:0] {StIdle, StTag, StData} state_e;
`else
  typedef enum logic [1:0] {StIdle, StData} state_e;
  logic [7:0] unused_tag_base;
  assign unused_tag_base = TAG_BASE;
`endif

  state_e          state_q, state_d;
  logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]  grant_q, grant_d;
  logic [15:0]     beat_cnt_q, beat_cnt_d;

  logic [7:0]      req_bytes [N_REQ];
  logic            pick_found;
  logic [IdW-1:0]  pick_idx;
  logic            beat_fire;
  logic            release_now;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_bytes[i] = req_data[8*i +: 8];
    end
  end

  // Search upward from rr_ptr+1 with wrap; the first hit wins, so the last
  // owner (rr_ptr) is checked last and has the lowest priority.
  always_comb begin
    int unsigned    idx;
    logic [IdW-1:0] idx_w;
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    idx_w      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx   = (32'(rr_ptr_q) + k) % N_REQ;
      idx_w = IdW'(idx);
      if (!pick_found && req_valid[idx_w]) begin
        pick_found = 1'b1;
        pick_idx   = idx_w;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    beat_cnt_d  = beat_cnt_q;
    tx_valid    = 1'b0;
    tx_data     = '0;
    req_ready   = '0;
    beat_fire   = 1'b0;
    release_now = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
`ifdef UART_TX_ARB_SRC_TAG_EN
          state_d    = StTag;
`else
          state_d    = StData;
`endif
        end
      end
`ifdef UART_TX_ARB_SRC_TAG_EN
      StTag: begin
        tx_valid = 1'b1;
        tx_data  = TAG_BASE | 8'(grant_q);
        if (tx_ready) begin
          state_d = StData;
        end
      end
`endif
      StData: begin
        tx_valid           = req_valid[grant_q];
        tx_data            = req_bytes[grant_q];
        req_ready[grant_q] = tx_ready;
        beat_fire          = req_valid[grant_q] && tx_ready;
        if (beat_fire) begin
          if (beat_cnt_q != 16'hFFFF) begin
            beat_cnt_d = beat_cnt_q + 16'd1;
          end
          // beat_cnt_q counts beats before this one, so +1 is this beat's ordinal.
          release_now = req_last[grant_q] ||
                        ((MAX_BEATS != 16'd0) && (beat_cnt_q + 16'd1 == MAX_BEATS));
          if (release_now) begin
            state_d  = StIdle;
            rr_ptr_d = grant_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= StIdle;
      rr_ptr_q   <= IdW'(N_REQ - 1);
      grant_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign grant_id = grant_q;

endmodule
